imem_responder: RTL

// - Memory-side responder for the proc2mem/mem2proc tagged bus driven by the instruction prefetcher and icache controller.
// - Accepts one BUS_LOAD/BUS_STORE per cycle, returns an accept tag, then returns data with that tag after fixed latency.
// - Synthesizable backing store plus tag pool; replaces the behavioural memory in fetch-path benches and FPGA builds.

---
 rtl/imem_responder_pkg.sv | 42 ++++
 rtl/imem_responder_if.sv | 23 ++
 rtl/mem_tag_alloc.sv | 49 ++++
 rtl/imem_responder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared bus types for the proc2mem/mem2proc tagged memory bus and the imem_responder.
package imem_responder_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned LFSR_W = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } MEM_RET_PACKET;

    localparam logic [LFSR_W-1:0] IMEM_LFSR_SEED = 16'hACE1;

    // Byte-lane enables for a store; lanes shifted past byte 7 fall off the word.
    function automatic logic [7:0] mem_byte_mask(MEM_SIZE size, logic [2:0] lane);
        logic [15:0] base;
        logic [15:0] shifted;
        case (size)
            BYTE:    base = 16'h0001;
            HALF:    base = 16'h0003;
            WORD:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        shifted = base << lane;
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// proc2mem request / mem2proc response bus between a requester (master) and memory (slave).
interface imem_responder_if;
    import imem_responder_pkg::*;

    BUS_COMMAND       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [XLEN-1:0]  proc2mem_data;
    MEM_SIZE          proc2mem_size;
    logic [TAG_W-1:0] mem2proc_response;
    logic [XLEN-1:0]  mem2proc_data;
    logic [TAG_W-1:0] mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_tag_alloc.sv
// Tag pool: free bitmap over tags 1..NUM_TAGS, lowest-free allocation, release by tag.
module mem_tag_alloc #(
    parameter int unsigned NUM_TAGS = 15,
    parameter int unsigned TAG_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_i,
    input  logic [TAG_W-1:0] free_tag_i,
    output logic [TAG_W-1:0] alloc_tag_c_o,
    output logic             full_c_o
);

    logic [NUM_TAGS:1] free_q;
    logic [NUM_TAGS:1] free_d;

    // Scan from the top so the lowest free tag wins.
    always_comb begin
        alloc_tag_c_o = '0;
        for (int t = int'(NUM_TAGS); t >= 1; t--) begin
            if (free_q[t]) begin
                alloc_tag_c_o = TAG_W'(t);
            end
        end
    end

    assign full_c_o = ~|free_q;

    always_comb begin
        free_d = free_q;
        for (int t = 1; t <= int'(NUM_TAGS); t++) begin
            if (free_tag_i == TAG_W'(t)) begin
                free_d[t] = 1'b1;
            end
            if (alloc_i && !full_c_o && (alloc_tag_c_o == TAG_W'(t))) begin
                free_d[t] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Tagged-bus memory responder: one request per cycle, accept tag next cycle, data after MEM_LATENCY.
// Define IMEM_RANDOM_STALL_EN to add LFSR-driven random request rejection.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned NUM_TAGS    = 15,
    parameter int unsigned MEM_WORDS   = 256
) (
    input  logic            clock,
    input  logic            reset,
    imem_responder_if.slave mem_bus
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [XLEN-1:0]  mem_q [MEM_WORDS];

    logic [IDX_W-1:0] word_idx_c;
    logic [2:0]       lane_c;
    logic [7:0]       byte_mask_c;
    logic [XLEN-1:0]  bit_mask_c;
    logic [XLEN-1:0]  rd_word_c;
    logic [XLEN-1:0]  wr_word_c;
    logic             is_store_c;
    logic             req_valid_c;
    logic             stall_c;
    logic             accept_c;
    logic             tags_full_c;
    logic [TAG_W-1:0] alloc_tag_c;
    logic             unused_addr_c;

    logic [TAG_W-1:0] resp_q;
    logic [TAG_W-1:0] resp_d;
    MEM_RET_PACKET    pipe_q [MEM_LATENCY];
    MEM_RET_PACKET    pipe_d;
    MEM_RET_PACKET    ret_q;

    assign word_idx_c    = mem_bus.proc2mem_addr[3 +: IDX_W];
    assign lane_c        = mem_bus.proc2mem_addr[2:0];
    assign unused_addr_c = ^mem_bus.proc2mem_addr[XLEN-1:3+IDX_W];
    assign is_store_c    = (mem_bus.proc2mem_command == BUS_STORE);
    assign req_valid_c   = (mem_bus.proc2mem_command != BUS_NONE);
    assign accept_c      = req_valid_c && !tags_full_c && !stall_c;

`ifdef IMEM_RANDOM_STALL_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; free-running regardless of traffic.
    assign lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall_c = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= IMEM_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_c = 1'b0;
`endif

    mem_tag_alloc #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_alloc (
        .clk_i         (clock),
        .rst_ni        (reset),
        .alloc_i       (accept_c),
        .free_tag_i    (ret_q.tag),
        .alloc_tag_c_o (alloc_tag_c),
        .full_c_o      (tags_full_c)
    );

    // Store merge: the returned word for a store is the post-write word.
    always_comb begin
        byte_mask_c = mem_byte_mask(mem_bus.proc2mem_size, lane_c);
        bit_mask_c  = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask_c[8*b +: 8] = {8{byte_mask_c[b]}};
        end
        rd_word_c = mem_q[word_idx_c];
        wr_word_c = (rd_word_c & ~bit_mask_c) | (mem_bus.proc2mem_data & bit_mask_c);
    end

    always_comb begin
        resp_d      = '0;
        pipe_d.tag  = '0;
        pipe_d.data = '0;
        if (accept_c) begin
            resp_d      = alloc_tag_c;
            pipe_d.tag  = alloc_tag_c;
            pipe_d.data = is_store_c ? wr_word_c : rd_word_c;
        end
    end

    always_ff @(posedge clock) begin
        if (accept_c && is_store_c) begin
            mem_q[word_idx_c] <= wr_word_c;
        end
    end

    // Fixed-latency return path; empty slots carry tag 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_q <= '0;
            ret_q  <= '0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            resp_q    <= resp_d;
            pipe_q[0] <= pipe_d;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            ret_q <= pipe_q[MEM_LATENCY-1];
        end
    end

    assign mem_bus.mem2proc_response = resp_q;
    assign mem_bus.mem2proc_tag      = ret_q.tag;
    assign mem_bus.mem2proc_data     = ret_q.data;

endmodule
